// File: rtl/id_exe_pipe_reg_if.sv
// ID->EXE handshake and payload bundle: decode side drives in_*, execute side drives out_ready.
interface id_exe_pipe_reg_if #(
    parameter int CW_W = 35,
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            bubble;
    logic            flush;
    logic [CW_W-1:0] control_word_in;
    logic [XLEN-1:0] rs1_in;
    logic [XLEN-1:0] rs2_in;
    logic [XLEN-1:0] immediate_in;
    logic [XLEN-1:0] pc_in;
    logic            out_valid;
    logic            out_ready;
    logic [CW_W-1:0] control_word_out;
    logic [XLEN-1:0] rs1_out;
    logic [XLEN-1:0] rs2_out;
    logic [XLEN-1:0] immediate_out;
    logic [XLEN-1:0] pc_out;

    modport master (
        output in_valid, bubble, flush, control_word_in, rs1_in, rs2_in, immediate_in, pc_in,
        output out_ready,
        input  in_ready, out_valid, control_word_out, rs1_out, rs2_out, immediate_out, pc_out
    );

    modport slave (
        input  in_valid, bubble, flush, control_word_in, rs1_in, rs2_in, immediate_in, pc_in,
        input  out_ready,
        output in_ready, out_valid, control_word_out, rs1_out, rs2_out, immediate_out, pc_out
    );
endinterface

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE two-entry skid buffer with flush and load-use bubble insertion.
// Optional stall/bubble performance counters: define ID_EXE_PERF_CNT_EN.
module id_exe_pipe_reg #(
    parameter int              CW_W   = 35,
    parameter int              XLEN   = 32,
    parameter logic [CW_W-1:0] NOP_CW = '0,
    parameter int              CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    id_exe_pipe_reg_if.slave   bus
`ifdef ID_EXE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
`endif
);
    localparam int E_W = CW_W + 4 * XLEN;

    logic           main_v_q, main_v_d;
    logic           skid_v_q, skid_v_d;
    logic [E_W-1:0] main_q, main_d;
    logic [E_W-1:0] skid_q, skid_d;
    logic [E_W-1:0] new_entry;
    logic           in_ready;
    logic           acc, ins, pop;

    assign in_ready = rst & ~skid_v_q & ~bus.bubble;
    assign acc      = bus.in_valid & in_ready;
    assign ins      = bus.bubble & ~skid_v_q & rst;
    assign pop      = main_v_q & bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_v_q;
    assign {bus.control_word_out, bus.rs1_out, bus.rs2_out, bus.immediate_out, bus.pc_out} = main_q;

    // acc and ins are mutually exclusive: in_ready is low whenever bubble is high.
    always_comb begin
        new_entry = ins ? {NOP_CW, {(3*XLEN){1'b0}}, bus.pc_in}
                        : {bus.control_word_in, bus.rs1_in, bus.rs2_in, bus.immediate_in, bus.pc_in};
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        if (bus.flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            main_d   = '0;
            skid_d   = '0;
        end else if (pop && skid_v_q) begin
            main_d   = skid_q;
            main_v_d = 1'b1;
            skid_v_d = 1'b0;
        end else if ((acc || ins) && (!main_v_q || pop)) begin
            main_d   = new_entry;
            main_v_d = 1'b1;
        end else if (acc || ins) begin
            skid_d   = new_entry;
            skid_v_d = 1'b1;
        end else if (pop) begin
            main_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

`ifdef ID_EXE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.in_valid && !in_ready && rst && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (ins && !bus.flush && (bubble_cnt_q != '1))
            bubble_cnt_d = bubble_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif
endmodule
